// File: rtl/alarm_sounder_pkg.sv
// alarm_sounder_pkg: shared state encodings for the alarm sounder and the display block that decodes state_o
package alarm_sounder_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
    localparam logic [1:0] ST_SNOOZE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        RING   = ST_RING,
        SNOOZE = ST_SNOOZE,
        DONE   = ST_DONE
    } state_t;

endpackage

// File: rtl/alarm_sounder_if.sv
// alarm_sounder_if: control inputs and buzzer/indicator outputs of the alarm sounder
//   ring_in, snooze, dismiss, tick_4hz, tick_1hz : controls and timing strobes into the sounder
//   buzzer, led, snoozing, snooze_cnt, state_o   : drive and status out of the sounder
interface alarm_sounder_if;

    logic       ring_in;
    logic       snooze;
    logic       dismiss;
    logic       tick_4hz;
    logic       tick_1hz;
    logic       buzzer;
    logic       led;
    logic       snoozing;
    logic [1:0] snooze_cnt;
    logic [1:0] state_o;

    modport master (
        output ring_in, snooze, dismiss, tick_4hz, tick_1hz,
        input  buzzer, led, snoozing, snooze_cnt, state_o
    );

    modport slave (
        input  ring_in, snooze, dismiss, tick_4hz, tick_1hz,
        output buzzer, led, snoozing, snooze_cnt, state_o
    );

endinterface

// File: rtl/alarm_sounder_tone_gen.sv
// alarm_tone_gen: square-wave tone, toggling every TONE_DIV cycles while en is high
//   CLK   : system clock
//   reset : asynchronous active-low reset
//   en    : run enable; when low the counter and tone are held at 0
//   tone  : registered tone output
module alarm_tone_gen #(
    parameter int TONE_DIV = 25000
) (
    input  logic CLK,
    input  logic reset,
    input  logic en,
    output logic tone
);

    localparam int W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TONE_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tone <= ~tone;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alarm_sounder.sv
// alarm_sounder: turns the alarm ring level into a patterned buzzer drive with snooze, dismiss, escalation and timeout
//   CLK   : system clock
//   reset : asynchronous active-low reset
//   bus   : slave side of alarm_sounder_if (ring_in/snooze/dismiss/ticks in; buzzer/led/snoozing/snooze_cnt/state_o out)
module alarm_sounder
    import alarm_sounder_pkg::*;
#(
    parameter int TONE_DIV   = 25000,
    parameter int SNOOZE_S   = 300,
    parameter int TIMEOUT_S  = 60,
    parameter int ESCALATE_S = 30,
    parameter int MAX_SNOOZE = 3
) (
    input  logic           CLK,
    input  logic           reset,
    alarm_sounder_if.slave bus
);

    localparam int SW = $clog2(((SNOOZE_S > TIMEOUT_S) ? SNOOZE_S : TIMEOUT_S) + 1);
    localparam logic [SW-1:0] SEC_ESC      = SW'(ESCALATE_S);
    localparam logic [SW-1:0] SEC_SNZ_LAST = SW'(SNOOZE_S - 1);
    localparam logic [SW-1:0] SEC_TO_LAST  = SW'(TIMEOUT_S - 1);
    localparam logic [1:0]    SNZ_MAX      = 2'(MAX_SNOOZE);

    state_t        state, n_state;
    logic [SW-1:0] sec_cnt, n_sec;
    logic [1:0]    phase, n_phase, snooze_cnt, n_snooze_cnt;
    logic          tone, gate, led, snoozing;

    always_comb begin
        n_state      = state;
        n_snooze_cnt = snooze_cnt;
        case (state)
            IDLE:   if (bus.ring_in) n_state = RING;
            RING:   if (!bus.ring_in) n_state = IDLE;
                    else if (bus.dismiss) n_state = DONE;
                    else if (bus.snooze && snooze_cnt < SNZ_MAX) begin
                        n_state      = SNOOZE;
                        n_snooze_cnt = snooze_cnt + 2'd1;
                    end else if (bus.tick_1hz && sec_cnt == SEC_TO_LAST) n_state = DONE;
            SNOOZE: if (!bus.ring_in) n_state = IDLE;
                    else if (bus.dismiss) n_state = DONE;
                    else if (bus.tick_1hz && sec_cnt == SEC_SNZ_LAST) n_state = RING;
            DONE:   if (!bus.ring_in) n_state = IDLE;
        endcase
        // Any state change clears the second counter, swallowing a coincident tick.
        n_sec = (n_state != state || n_state == IDLE || n_state == DONE) ? '0 : sec_cnt + SW'(bus.tick_1hz);
        // Phase restarts on every entry to RING but keeps running into SNOOZE for the LED blink.
        n_phase = (n_state == IDLE || n_state == DONE || (n_state == RING && state != RING)) ? '0 : phase + 2'(bus.tick_4hz);
        if (n_state == IDLE) n_snooze_cnt = '0;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sec_cnt    <= '0;
            phase      <= '0;
            snooze_cnt <= '0;
            gate       <= 1'b0;
            led        <= 1'b0;
            snoozing   <= 1'b0;
        end else begin
            state      <= n_state;
            sec_cnt    <= n_sec;
            phase      <= n_phase;
            snooze_cnt <= n_snooze_cnt;
            gate       <= n_state == RING && (n_sec >= SEC_ESC || !n_phase[0]);
            led        <= n_state == RING || (n_state == SNOOZE && n_phase[1]);
            snoozing   <= n_state == SNOOZE;
        end
    end

    alarm_tone_gen #(.TONE_DIV(TONE_DIV)) u_tone (
        .CLK   (CLK),
        .reset (reset),
        .en    (state == RING),
        .tone  (tone)
    );

    // Both operands are flops; gate is already 0 outside RING, masking a tone edge taken on the exit clock.
    assign bus.buzzer     = tone & gate;
    assign bus.led        = led;
    assign bus.snoozing   = snoozing;
    assign bus.snooze_cnt = snooze_cnt;
    assign bus.state_o    = state;

endmodule

// File: tb/tb_alarm_sounder.sv
// tb_alarm_sounder: vector table, corner sequences and random stimulus against a behavioural model of alarm_sounder
module tb_alarm_sounder;

    localparam int TD = 2, SS = 3, TO = 5, ES = 2, MS = 2;

    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;

    alarm_sounder_if bus();

    alarm_sounder #(
        .TONE_DIV(TD), .SNOOZE_S(SS), .TIMEOUT_S(TO), .ESCALATE_S(ES), .MAX_SNOOZE(MS)
    ) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0, n_fail = 0;
    int m_st, m_sec, m_q, m_sn, m_k;

    typedef struct {
        logic [4:0] in;
        logic [1:0] st, sn;
        logic       snz, led;
    } vec_t;
    vec_t tv[$];

    function automatic void add(input logic [4:0] in, input logic [1:0] st, sn, input logic snz, led);
        vec_t v;
        v.in = in; v.st = st; v.sn = sn; v.snz = snz; v.led = led;
        tv.push_back(v);
    endfunction

    task automatic model_reset();
        m_st = 0; m_sec = 0; m_q = 0; m_sn = 0; m_k = 0;
    endtask

    task automatic model_step(input logic [4:0] v);
        int ns;
        ns = m_st;
        if (m_st == 0) ns = v[4] ? 1 : 0;
        else if (!v[4]) ns = 0;
        else if (m_st == 3) ns = 3;
        else if (v[2]) ns = 3;
        else if (m_st == 1 && v[3] && m_sn < MS) begin ns = 2; m_sn++; end
        else if (v[0] && m_sec == ((m_st == 1) ? TO : SS) - 1) ns = (m_st == 1) ? 3 : 1;
        m_sec = (ns != m_st || ns == 0 || ns == 3) ? 0 : m_sec + int'(v[0]);
        m_q   = (ns == 2 || (ns == 1 && m_st == 1)) ? (m_q + int'(v[1])) % 4 : 0;
        m_k   = (ns == 1) ? ((m_st == 1) ? m_k + 1 : 1) : 0;
        if (ns == 0) m_sn = 0;
        m_st = ns;
    endtask

    function automatic logic exp_buzz();
        logic tone_bit;
        tone_bit = (m_k >= 1) && (((m_k - 1) / TD) % 2 == 1);
        return m_st == 1 && tone_bit && (m_sec >= ES || m_q % 2 == 0);
    endfunction

    function automatic logic exp_led();
        return m_st == 1 || (m_st == 2 && m_q >= 2);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " state"},    32'(bus.state_o),    32'(m_st));
        chk({tag, " sn_cnt"},   32'(bus.snooze_cnt), 32'(m_sn));
        chk({tag, " snoozing"}, 32'(bus.snoozing),   32'(m_st == 2));
        chk({tag, " led"},      32'(bus.led),        32'(exp_led()));
        chk({tag, " buzzer"},   32'(bus.buzzer),     32'(exp_buzz()));
    endtask

    task automatic drive(input logic [4:0] v);
        {bus.ring_in, bus.snooze, bus.dismiss, bus.tick_4hz, bus.tick_1hz} = v;
        @(posedge clk);
        if (reset) model_step(v);
        @(negedge clk);
    endtask

    logic [4:0] b_in [17];
    logic       b_exp[17];

    initial begin
        {bus.ring_in, bus.snooze, bus.dismiss, bus.tick_4hz, bus.tick_1hz} = 5'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset state",    32'(bus.state_o),    0);
        chk("reset buzzer",   32'(bus.buzzer),     0);
        chk("reset led",      32'(bus.led),        0);
        chk("reset snoozing", 32'(bus.snoozing),   0);
        chk("reset sn_cnt",   32'(bus.snooze_cnt), 0);
        reset = 1'b1;

        // {ring_in, snooze, dismiss, tick_4hz, tick_1hz} -> state, snooze_cnt, snoozing, led
        add(5'b00000, 0, 0, 0, 0);
        add(5'b10000, 1, 0, 0, 1);
        add(5'b10001, 1, 0, 0, 1);
        add(5'b11000, 2, 1, 1, 0);
        add(5'b10010, 2, 1, 1, 0);
        add(5'b10011, 2, 1, 1, 1);
        add(5'b10001, 2, 1, 1, 1);
        add(5'b10001, 1, 1, 0, 1);
        add(5'b11000, 2, 2, 1, 0);
        add(5'b11000, 2, 2, 1, 0);
        add(5'b10001, 2, 2, 1, 0);
        add(5'b10001, 2, 2, 1, 0);
        add(5'b10001, 1, 2, 0, 1);
        add(5'b11000, 1, 2, 0, 1);
        for (int i = 0; i < 4; i++) add(5'b10001, 1, 2, 0, 1);
        add(5'b10001, 3, 2, 0, 0);
        add(5'b10000, 3, 2, 0, 0);
        add(5'b00000, 0, 0, 0, 0);
        add(5'b10000, 1, 0, 0, 1);
        add(5'b01100, 0, 0, 0, 0);
        add(5'b10000, 1, 0, 0, 1);
        add(5'b11100, 3, 0, 0, 0);
        add(5'b00000, 0, 0, 0, 0);
        add(5'b10000, 1, 0, 0, 1);
        add(5'b11000, 2, 1, 1, 0);
        add(5'b10100, 3, 1, 0, 0);
        add(5'b00000, 0, 0, 0, 0);
        add(5'b10000, 1, 0, 0, 1);
        add(5'b11000, 2, 1, 1, 0);
        add(5'b00000, 0, 0, 0, 0);
        foreach (tv[i]) begin
            drive(tv[i].in);
            chk($sformatf("vec%0d state", i),    32'(bus.state_o),    32'(tv[i].st));
            chk($sformatf("vec%0d sn_cnt", i),   32'(bus.snooze_cnt), 32'(tv[i].sn));
            chk($sformatf("vec%0d snoozing", i), 32'(bus.snoozing),   32'(tv[i].snz));
            chk($sformatf("vec%0d led", i),      32'(bus.led),        32'(tv[i].led));
            chk($sformatf("vec%0d buzzer", i),   32'(bus.buzzer),     32'(exp_buzz()));
        end

        // Beep pattern then escalation to continuous tone after two seconds.
        b_in  = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10010, 5'b10000, 5'b10000, 5'b10000, 5'b10010,
                  5'b10000, 5'b10000, 5'b10000, 5'b10001, 5'b10001, 5'b10010, 5'b10000, 5'b10000};
        b_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 17; i++) begin
            drive(b_in[i]);
            chk($sformatf("beep%0d buzzer", i), 32'(bus.buzzer), 32'(b_exp[i]));
            chk($sformatf("beep%0d state", i),  32'(bus.state_o), 1);
        end
        drive(5'b00000);
        chk_model("beep end");

        // Snooze coinciding with a 1 Hz tick: the tick is swallowed by the entry clear.
        drive(5'b10000);
        drive(5'b10001);
        drive(5'b11001);
        chk("coinc enter state", 32'(bus.state_o), 2);
        chk("coinc sn_cnt",      32'(bus.snooze_cnt), 1);
        drive(5'b10001);
        chk("coinc tick1 state", 32'(bus.state_o), 2);
        drive(5'b10001);
        chk("coinc tick2 state", 32'(bus.state_o), 2);
        drive(5'b10001);
        chk("coinc expire state", 32'(bus.state_o), 1);
        chk_model("coinc");

        // Asynchronous reset in the middle of a snooze.
        drive(5'b00000);
        drive(5'b10000);
        drive(5'b11000);
        chk("pre-reset state",  32'(bus.state_o),    2);
        chk("pre-reset sn_cnt", 32'(bus.snooze_cnt), 1);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("async state",    32'(bus.state_o),    0);
        chk("async snoozing", 32'(bus.snoozing),   0);
        chk("async sn_cnt",   32'(bus.snooze_cnt), 0);
        chk("async led",      32'(bus.led),        0);
        chk("async buzzer",   32'(bus.buzzer),     0);
        drive(5'b10000);
        chk("held reset state", 32'(bus.state_o), 0);
        reset = 1'b1;
        drive(5'b10000);
        chk("release state",  32'(bus.state_o),    1);
        chk("release sn_cnt", 32'(bus.snooze_cnt), 0);
        chk_model("release");

        for (int i = 0; i < 800; i++) begin
            drive({$urandom_range(0, 24) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0});
            chk_model($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
